// File: rtl/cla_pkg.sv
// Shared types and default sizing for the block-serial carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_W = 64;
  localparam int DEFAULT_N = 16;

endpackage

// File: rtl/cla_chunk_adder.sv
// One N-bit lookahead chunk: bit carries, chunk sum and group propagate/generate.
module cla_chunk_adder
  import cla_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         P,
  output logic         G,
  output logic         co,
  output logic         c_msb
);

  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   c;
  logic [N:0]   gc;

  assign p = a ^ b;
  assign g = a & b;

  // gc is the same chain seeded with 0, which is the chunk's group generate
  always_comb begin
    c     = '0;
    gc    = '0;
    c[0]  = ci;
    gc[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      c[i+1]  = g[i] | (p[i] & c[i]);
      gc[i+1] = g[i] | (p[i] & gc[i]);
    end
  end

  assign s     = p ^ c[N-1:0];
  assign P     = &p;
  assign G     = gc[N];
  assign co    = c[N];
  assign c_msb = c[N-1];

endmodule

// File: rtl/block_serial_cla_adder.sv
// W-bit adder that processes one N-bit lookahead chunk per cycle behind a
// valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | in_ready=1, waiting to capture a, b, cin
// RUN   | one chunk per cycle, index 0..K-1
// DONE  | out_valid=1, result held until out_ready
module block_serial_cla_adder
  import cla_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int K  = W / N;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q, sum_q;
  logic           carry_q, cout_q, ovf_q;
  logic [IW-1:0]  idx_q;

  logic [N-1:0]   a_c, b_c, s_c;
  logic           p_grp, g_grp, co_c, cmsb_c;
  logic           last;

  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int k = 0; k < K; k++) begin
      if (idx_q == IW'(k)) begin
        a_c = a_q[k*N +: N];
        b_c = b_q[k*N +: N];
      end
    end
  end

  assign last = (idx_q == IW'(K - 1));

  cla_chunk_adder #(.N(N)) u_chunk (
    .a     (a_c),
    .b     (b_c),
    .ci    (carry_q),
    .s     (s_c),
    .P     (p_grp),
    .G     (g_grp),
    .co    (co_c),
    .c_msb (cmsb_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          carry_q <= g_grp | (p_grp & carry_q);
          idx_q   <= idx_q + IW'(1);
          for (int k = 0; k < K; k++) begin
            if (idx_q == IW'(k)) sum_q[k*N +: N] <= s_c;
          end
          if (last) begin
            cout_q <= co_c;
            ovf_q  <= co_c ^ cmsb_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_block_serial_cla_adder.sv
// Bench for block_serial_cla_adder at W=64 with N=16, N=64 (K=1) and N=1,
// checked against plain-arithmetic a+b+cin.
module tb_block_serial_cla_adder;

  logic        clk;
  logic        rst;
  logic [63:0] op_a, op_b;
  logic        op_cin;
  logic        iv  [3];
  logic        ir  [3];
  logic        ov  [3];
  logic        ord [3];
  logic [63:0] s   [3];
  logic        co  [3];
  logic        of  [3];

  int n_cmp = 0;
  int n_bad = 0;

  block_serial_cla_adder #(.W(64), .N(16)) u_n16 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(op_a), .b(op_b),
    .cin(op_cin), .out_valid(ov[0]), .out_ready(ord[0]), .sum(s[0]), .cout(co[0]), .ovf(of[0]));

  block_serial_cla_adder #(.W(64), .N(64)) u_n64 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(op_a), .b(op_b),
    .cin(op_cin), .out_valid(ov[1]), .out_ready(ord[1]), .sum(s[1]), .cout(co[1]), .ovf(of[1]));

  block_serial_cla_adder #(.W(64), .N(1)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(op_a), .b(op_b),
    .cin(op_cin), .out_valid(ov[2]), .out_ready(ord[2]), .sum(s[2]), .cout(co[2]), .ovf(of[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on DUT sel; hold = cycles out_ready stays low in DONE.
  task automatic do_op(input int sel, input logic [63:0] x, input logic [63:0] y,
                       input logic c, input int hold);
    int          k;
    int          cyc;
    logic [64:0] full;
    logic        exp_ovf;
    k       = (sel == 0) ? 4 : (sel == 1) ? 1 : 64;
    full    = {1'b0, x} + {1'b0, y} + {64'd0, c};
    exp_ovf = (x[63] == y[63]) && (full[63] != x[63]);

    check("idle_ready", {127'd0, ir[sel]}, 128'd1);
    op_a = x; op_b = y; op_cin = c;
    iv[sel]  = 1'b1;
    ord[sel] = 1'($urandom_range(0, 1));
    step();
    iv[sel] = 1'b0;
    op_a = rnd64(); op_b = rnd64(); op_cin = 1'($urandom_range(0, 1));

    cyc = 0;
    while (!ov[sel] && cyc < 100) begin
      ord[sel] = 1'($urandom_range(0, 1));
      iv[sel]  = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    check("latency", 128'(cyc), 128'(k));

    for (int h = 0; h < hold; h++) begin
      ord[sel] = 1'b0;
      iv[sel]  = 1'($urandom_range(0, 1));
      op_a = rnd64(); op_b = rnd64();
      check("hold", {60'd0, ov[sel], ir[sel], co[sel], of[sel], s[sel]},
            {60'd0, 1'b1, 1'b0, full[64], exp_ovf, full[63:0]});
      step();
    end

    iv[sel]  = 1'b0;
    ord[sel] = 1'b1;
    check("result", {62'd0, ov[sel], co[sel], of[sel], s[sel]},
          {62'd0, 1'b1, full[64], exp_ovf, full[63:0]});
    step();
    ord[sel] = 1'b0;
    check("release", {126'd0, ov[sel], ir[sel]}, 128'd1);
  endtask

  task automatic rand_ops(input int sel, input int count);
    logic [63:0] x, y;
    for (int i = 0; i < count; i++) begin
      x = rnd64();
      case ($urandom_range(0, 3))
        0: y = rnd64();
        1: y = ~x;
        2: y = x;
        default: begin x = 64'hFFFF_FFFF_FFFF_FFFF; y = {63'd0, 1'($urandom_range(0, 1))}; end
      endcase
      do_op(sel, x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    op_a = '0; op_b = '0; op_cin = 1'b0;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ord[i] = 1'b0; end
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      check("reset_state", {61'd0, ir[i], ov[i], co[i], of[i], s[i]}, {61'd0, 1'b1, 67'd0});

    do_op(0, 64'h1, 64'h2, 1'b0, 0);
    do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0);
    do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);
    do_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1);
    do_op(0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 5);
    do_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 2);
    do_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 2);
    do_op(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);

    // Abort on the second RUN cycle
    op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'h1; op_cin = 1'b1;
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_state", {63'd0, ir[0], ov[0], co[0], of[0], s[0]}, {63'd0, 1'b1, 67'd0});
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | ov[0];
      step();
    end
    check("abort_no_pulse", {127'd0, seen}, 128'd0);

    rand_ops(0, 1000);
    rand_ops(1, 1000);
    rand_ops(2, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_serial_cla_adder.md
BLOCK_SERIAL_CLA_ADDER -- requirements
Module: block_serial_cla_adder

Interface
REQ-001 SHALL have parameter W, default 64: total operand width in bits.
REQ-002 SHALL have parameter N, default 16: chunk width in bits, one chunk per cycle; W SHALL be an integer multiple of N, with N >= 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and cin are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts an operation.
REQ-007 SHALL have port a, input, W bits: addend A.
REQ-008 SHALL have port b, input, W bits: addend B.
REQ-009 SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port sum, output, W bits: a + b + cin modulo 2^W.
REQ-013 SHALL have port cout, output, 1 bit: carry out of bit W-1.
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement overflow, defined as cout XOR the carry into bit W-1.

Function
REQ-015 SHALL use a three-state FSM with states IDLE, RUN and DONE; K = W/N.
REQ-016 In IDLE, in_ready SHALL be 1; when in_valid is 1, the block SHALL capture a, b and cin, clear the chunk index and go to RUN.
REQ-017 In RUN, for each chunk k (bits k*N+N-1..k*N), the block SHALL form p = a^b and g = a&b.
REQ-018 In RUN, the chunk carries SHALL be formed as c[i+1] = g[i] | p[i]&c[i], with c[0] equal to the carry register.
REQ-019 In RUN, the chunk sum SHALL be p ^ c[N-1:0] and SHALL be written to sum bits k*N+N-1..k*N.
REQ-020 In RUN, the carry register SHALL update to G | (P & carry), where P = &p and G is the group generate of the chunk.
REQ-021 After chunk K-1 is processed, the FSM SHALL go to DONE; the capture edge plus K edges yields out_valid = 1.
REQ-022 In DONE, out_valid SHALL be 1, and sum, cout and ovf SHALL hold stable until out_ready is 1.
REQ-023 When out_valid and out_ready are both 1, the FSM SHALL return to IDLE on that edge; there is no back-to-back overlap.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid SHALL be ignored outside IDLE, and a and b are not sampled there.
REQ-025 Outputs SHALL change only while in RUN or on capture; sum bits from the previous operation MAY persist until overwritten.
REQ-026 When K = 1, the block SHALL complete in one RUN cycle.
REQ-027 A carry generated in chunk 0 SHALL ripple correctly through all-propagate chunks, e.g. all-ones + 1 gives sum 0 and cout 1.

Reset
REQ-028 When rst = 1 at a clock edge, the FSM SHALL go to IDLE; sum, cout, ovf, out_valid and the carry register SHALL go to 0; in_ready SHALL be 1 on the next cycle.
REQ-029 Reset in RUN or DONE SHALL abort the operation silently, and no out_valid pulse SHALL follow.
REQ-030 rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-031 Shared package cla_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default W and N constants.
REQ-032 The per-chunk p/g/carry/sum logic SHALL be one combinational sub-module, cla_chunk_adder, with inputs a, b, ci and outputs s, P, G, co and c_msb (carry into the MSB).
REQ-033 The chunk index counter SHALL be $clog2(K) bits wide, with a minimum of 1 bit.

Verification
REQ-034 With W=64, N=16: a=0x0000_0000_0000_0001, b=0x0000_0000_0000_0002, cin=0 -> sum=0x3, cout=0, ovf=0, out_valid asserted 4 cycles after capture.
REQ-035 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
REQ-036 a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> out_valid and sum stay stable; in_valid pulses during this time are ignored (in_ready=0).
REQ-038 Assert rst on the 2nd RUN cycle -> next cycle is IDLE with in_ready=1 and all outputs 0; no out_valid pulse follows.
REQ-039 Run 1000 random a, b and cin with random out_ready -> {cout,sum} equals a+b+cin at every handshake; repeat with N=64 (K=1) and N=1.
